// File: rtl/hs4_rx_endpoint.sv
// hs4_rx_endpoint
//
// Receiving side of a four-phase req/ack handshake that crosses into the
// clock domain. The incoming request passes through a synchronizer chain.
// While the request is seen high, the accompanying data word is captured
// into a one-entry valid/ready buffer and a registered acknowledge is
// returned. The acknowledge drops once the synchronized request falls.
// Completed captures are counted modulo 2^CNT_W for debug.
//
// Ports:
//   clock      sole clock, rising edge
//   reset      synchronous, active-high; clears all state
//   req_in     request from the transmitter (asynchronous to clock)
//   data_in    transfer word; the transmitter holds it stable while req_in
//              is high and until it sees ack_out high
//   ack_out    registered acknowledge back to the transmitter
//   out_valid  buffered word available to local logic
//   out_ready  local logic accepts the buffered word
//   out_data   buffered word; holds its last value after it drains
//   xfer_count number of captures since reset (wraps)
//
// State table:
//   state    | meaning
//   ST_IDLE  | ack_out low; waiting for req_s high with buffer space
//   ST_ACK   | word captured, ack_out high; waiting for req_s to fall
module hs4_rx_endpoint #(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  xfer_count
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("hs4_rx_endpoint: SYNC_STAGES must be in 2..4");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   valid_q, valid_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic req_s;
  logic drain;
  logic can_accept;
  logic capture;

  // Only the first stage of the chain sees req_in; req_s is the last stage.
  assign req_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], req_in};
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    count_d    = count_q;
    drain      = valid_q & out_ready;
    // A full buffer that drains this cycle may be refilled in the same edge.
    can_accept = ~valid_q | out_ready;
    capture    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_s && can_accept) begin
          capture = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Captures happen only from IDLE, so a re-risen request must wait
        // for the full return-to-zero first.
        if (!req_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (capture) begin
      valid_d = 1'b1;
      data_d  = data_in;
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  // All outputs come straight from flops.
  assign ack_out    = (state_q == ST_ACK);
  assign out_valid  = valid_q;
  assign out_data   = data_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_hs4_rx_endpoint.sv
module tb_hs4_rx_endpoint;

  localparam int DATA_W      = 32;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 8;
  localparam int WAIT_LIMIT  = 200;

  logic              clock;
  logic              reset;
  logic              req_in;
  logic [DATA_W-1:0] data_in;
  logic              ack_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  xfer_count;

  int checks;
  int errors;
  int exp_count; // reference transfer count, modulo 2^CNT_W

  hs4_rx_endpoint #(
    .DATA_W     (DATA_W),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_W      (CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_in    (req_in),
    .data_in   (data_in),
    .ack_out   (ack_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .xfer_count(xfer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_in = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    exp_count = 0;
  endtask

  // Transmitter side of one full four-phase handshake.
  task automatic send(input logic [DATA_W-1:0] w);
    int n;
    data_in = w;
    req_in = 1'b1;
    n = 0;
    while (ack_out !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    checks++;
    if (ack_out !== 1'b1) begin
      errors++;
      $display("FAIL send_ack_rise: ack_out=%b expected 1 within %0d cycles", ack_out, WAIT_LIMIT);
    end
    exp_count = (exp_count + 1) % (1 << CNT_W);
    req_in = 1'b0;
    n = 0;
    while (ack_out !== 1'b0 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    checks++;
    if (ack_out !== 1'b0) begin
      errors++;
      $display("FAIL send_ack_fall: ack_out=%b expected 0 within %0d cycles", ack_out, WAIT_LIMIT);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_in = 1'b1;
    data_in = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    step();
    step();
    checks++;
    if ({ack_out, out_valid, out_data, xfer_count} !== '0) begin
      errors++;
      $display("FAIL reset_state: ack=%b valid=%b data=%h count=%h expected all 0",
               ack_out, out_valid, out_data, xfer_count);
    end
    req_in = 1'b0;
    step();
    reset = 1'b0;
    exp_count = 0;
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    data_in = 32'hA5A5_0001;
    req_in = 1'b1;      // sampled high at edge N
    step();             // after N
    checks++;
    if (ack_out !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack_early_n: ack_out=%b expected 0", ack_out);
    end
    step();             // after N+1
    checks++;
    if (ack_out !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_ack_early_n1: ack=%b valid=%b expected 0 0", ack_out, out_valid);
    end
    step();             // after N+2
    checks++;
    if (ack_out !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || xfer_count !== 8'd1) begin
      errors++;
      $display("FAIL basic_capture: ack=%b valid=%b data=%h count=%h expected 1 1 a5a50001 01",
               ack_out, out_valid, out_data, xfer_count);
    end
    exp_count = 1;
    step();
    step();
    req_in = 1'b0;      // sampled low at edge M
    step();             // after M
    step();             // after M+1
    checks++;
    if (ack_out !== 1'b1) begin
      errors++;
      $display("FAIL basic_ack_hold_m1: ack_out=%b expected 1", ack_out);
    end
    step();             // after M+2
    checks++;
    if (ack_out !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL basic_ack_fall: ack=%b valid=%b data=%h expected 0 0 a5a50001",
               ack_out, out_valid, out_data);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(32'h11);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL bp_first: valid=%b data=%h expected 1 00000011", out_valid, out_data);
    end
    data_in = 32'h22;
    req_in = 1'b1;
    repeat (6) step();
    checks++;
    if (ack_out !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h11) begin
      errors++;
      $display("FAIL bp_held: ack=%b valid=%b data=%h expected 0 1 00000011", ack_out, out_valid, out_data);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    checks++;
    if (ack_out !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h22 || xfer_count !== CNT_W'(exp_count)) begin
      errors++;
      $display("FAIL bp_refill: ack=%b valid=%b data=%h count=%h expected 1 1 00000022 %h",
               ack_out, out_valid, out_data, xfer_count, CNT_W'(exp_count));
    end
    req_in = 1'b0;
    repeat (4) step();
    checks++;
    if (ack_out !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: ack=%b valid=%b expected 0 1", ack_out, out_valid);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h22) begin
      errors++;
      $display("FAIL bp_drain: valid=%b data=%h expected 0 00000022", out_valid, out_data);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] w;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = $urandom;
      send(w);
      checks++;
      if (out_data !== w) begin
        errors++;
        $display("FAIL wrap_data[%0d]: out_data=%h expected %h", i, out_data, w);
      end
    end
    checks++;
    if (xfer_count !== 8'h00 || xfer_count !== CNT_W'(exp_count)) begin
      errors++;
      $display("FAIL wrap_256: xfer_count=%h expected 00", xfer_count);
    end
    send(32'h0000_0257);
    checks++;
    if (xfer_count !== 8'h01) begin
      errors++;
      $display("FAIL wrap_257: xfer_count=%h expected 01", xfer_count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    out_ready = 1'b0;
    data_in = 32'h5EED_0042;
    req_in = 1'b1;
    n = 0;
    while (ack_out !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    checks++;
    if (ack_out !== 1'b1) begin
      errors++;
      $display("FAIL rmid_enter_ack: ack_out=%b expected 1", ack_out);
    end
    reset = 1'b1;
    step();             // reset edge R
    reset = 1'b0;
    exp_count = 0;
    checks++;
    if ({ack_out, out_valid, out_data, xfer_count} !== '0) begin
      errors++;
      $display("FAIL rmid_cleared: ack=%b valid=%b data=%h count=%h expected all 0",
               ack_out, out_valid, out_data, xfer_count);
    end
    step();             // R+1
    step();             // R+2
    checks++;
    if (ack_out !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmid_early: ack=%b valid=%b expected 0 0", ack_out, out_valid);
    end
    step();             // R+3
    checks++;
    if (ack_out !== 1'b1 || out_valid !== 1'b1 || out_data !== 32'h5EED_0042 || xfer_count !== 8'd1) begin
      errors++;
      $display("FAIL rmid_recapture: ack=%b valid=%b data=%h count=%h expected 1 1 5eed0042 01",
               ack_out, out_valid, out_data, xfer_count);
    end
    exp_count = 1;
    req_in = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_glitch();
    int n;
    do_reset();
    out_ready = 1'b1;
    data_in = 32'h6117_C400;
    req_in = 1'b1;
    n = 0;
    while (ack_out !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    exp_count = 1;
    // Low pulse entirely between two rising edges.
    for (int i = 0; i < 3; i++) begin
      req_in = 1'b0;
      #3;
      req_in = 1'b1;
      data_in = $urandom;
      step();
    end
    repeat (3) step();
    checks++;
    if (ack_out !== 1'b1 || xfer_count !== 8'd1 || out_valid !== 1'b0 || out_data !== 32'h6117_C400) begin
      errors++;
      $display("FAIL glitch_ignored: ack=%b count=%h valid=%b data=%h expected 1 01 0 6117c400",
               ack_out, xfer_count, out_valid, out_data);
    end
    req_in = 1'b0;      // first low sample at edge M
    step();             // after M
    step();             // after M+1
    checks++;
    if (ack_out !== 1'b1) begin
      errors++;
      $display("FAIL glitch_long_m1: ack_out=%b expected 1", ack_out);
    end
    step();             // after M+2
    checks++;
    if (ack_out !== 1'b0) begin
      errors++;
      $display("FAIL glitch_long_m2: ack_out=%b expected 0", ack_out);
    end
    out_ready = 1'b0;
  endtask

  // Random transmitter gaps and random consumer readiness; every word sent
  // must come out exactly once, in order.
  task automatic test_random();
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] w;
    bit tx_done;
    int guard;
    do_reset();
    tx_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          w = $urandom;
          q.push_back(w);
          send(w);
          repeat ($urandom_range(0, 3)) step();
        end
        tx_done = 1'b1;
      end
      begin
        guard = 0;
        while (!(tx_done && q.size() == 0) && guard < 20000) begin
          @(posedge clock);
          #2;
          out_ready = ($urandom_range(0, 2) != 0);
          @(negedge clock);
          if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL rand_extra_word: out_data=%h with nothing expected", out_data);
            end else begin
              if (out_data !== q[0]) begin
                errors++;
                $display("FAIL rand_data: out_data=%h expected %h", out_data, q[0]);
              end
              void'(q.pop_front());
            end
          end
          guard++;
        end
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL rand_timeout: %0d words never delivered", q.size());
        end
      end
    join
    step();
    out_ready = 1'b0;
    checks++;
    if (xfer_count !== CNT_W'(exp_count) || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_count: count=%h valid=%b expected %h 0", xfer_count, out_valid, CNT_W'(exp_count));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_count = 0;
    reset = 1'b1;
    req_in = 1'b0;
    data_in = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
